plic_claim_sequencer: RTL and testbench

Hardware claim/complete agent for the platform PLIC. Each target's `irq` line triggers a claim read of that target's claim/complete register over a single shared REG-bus master port. The sequencer then hands the claimed source ID to the hart with a valid/ack handshake, and writes the ID back as completion once the hart signals end-of-interrupt. It sits between the PLIC's register port (via the reg crossbar) and the harts, and replaces software claim/complete polling.

---
 rtl/plic_seq_pkg.sv | 28 ++
 rtl/plic_seq_rr_arb.sv | 55 +++++
 rtl/plic_claim_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_plic_claim_sequencer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_seq_pkg.sv
// Shared types, default addresses and the claim/complete address helper
// used by the PLIC claim sequencer and its round-robin arbiter.
package plic_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM,
    DELIVER,
    SERVICE,
    COMPLETE
  } tgt_state_e;

  typedef enum logic {
    BUS_IDLE,
    BUS_WAIT
  } bus_state_e;

  localparam logic [31:0] CC_BASE_DEFAULT   = 32'h0020_0004;
  localparam logic [31:0] CC_STRIDE_DEFAULT = 32'h0000_1000;

  // Computed at 64 bits so any ADDR_WIDTH up to 64 can size-cast the result.
  function automatic logic [63:0] cc_addr(input logic [63:0] base,
                                          input logic [63:0] stride,
                                          input int unsigned idx);
    return base + stride * 64'(idx);
  endfunction

endpackage

// File: rtl/plic_seq_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer advances past the last grantee when its transfer is done.
module plic_seq_rr_arb #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic          done_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gntIdx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] owner_q;
  logic          found;

  // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    gnt_o    = '0;
    gntIdx_o = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (IW'(i) >= ptr_q)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        gntIdx_o = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        gntIdx_o = IW'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      if (en_i) begin
        owner_q <= gntIdx_o;
      end
      if (done_i) begin
        ptr_q <= (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/plic_claim_sequencer.sv
// Hardware claim/complete agent: per-target FSMs claim IDs from the PLIC over
// one shared REG master port, hand them to harts and write them back on EOI.
module plic_claim_sequencer
  import plic_seq_pkg::*;
#(
  parameter int unsigned           SOURCE_NUM = 32,
  parameter int unsigned           TARGET_NUM = 2,
  parameter int unsigned           SRCW       = $clog2(SOURCE_NUM),
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] CC_BASE    = ADDR_WIDTH'(CC_BASE_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] CC_STRIDE  = ADDR_WIDTH'(CC_STRIDE_DEFAULT)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [TARGET_NUM-1:0]      irq_i,
  output logic [TARGET_NUM-1:0]      irq_valid_o,
  output logic [TARGET_NUM*SRCW-1:0] irq_id_o,
  input  logic [TARGET_NUM-1:0]      irq_ack_i,
  input  logic [TARGET_NUM-1:0]      eoi_i,
  output logic [TARGET_NUM-1:0]      err_o,
  output logic                       reg_valid_o,
  output logic                       reg_write_o,
  output logic [ADDR_WIDTH-1:0]      reg_addr_o,
  output logic [DATA_WIDTH-1:0]      reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]    reg_wstrb_o,
  input  logic [DATA_WIDTH-1:0]      reg_rdata_i,
  input  logic                       reg_error_i,
  input  logic                       reg_ready_i
);

  localparam int unsigned IW = (TARGET_NUM > 1) ? $clog2(TARGET_NUM) : 1;
  localparam int unsigned SW = DATA_WIDTH / 8;

  tgt_state_e      tgtState_q [TARGET_NUM];
  tgt_state_e      tgtState_d [TARGET_NUM];
  logic [SRCW-1:0] claimId_q  [TARGET_NUM];
  logic [SRCW-1:0] claimId_d  [TARGET_NUM];

  logic [TARGET_NUM-1:0] err_q, err_d;
  logic [TARGET_NUM-1:0] req, resp, completeVec;

  bus_state_e       busState_q, busState_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             regValid_q, regValid_d;
  logic             regWrite_q, regWrite_d;
  logic [ADDR_WIDTH-1:0] regAddr_q, regAddr_d;
  logic [DATA_WIDTH-1:0] regWdata_q, regWdata_d;
  logic [SW-1:0]    regWstrb_q, regWstrb_d;

  logic [TARGET_NUM-1:0] gnt;
  logic [IW-1:0]    gntIdx;
  logic             arbEn, arbDone;

  plic_seq_rr_arb #(
    .N  (TARGET_NUM),
    .IW (IW)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req),
    .en_i     (arbEn),
    .done_i   (arbDone),
    .gnt_o    (gnt),
    .gntIdx_o (gntIdx)
  );

  if (DATA_WIDTH > SRCW) begin : g_rdata_upper
    logic unusedRdataUpper;
    assign unusedRdataUpper = ^reg_rdata_i[DATA_WIDTH-1:SRCW];
  end

  // A target may only be answered while the bus is waiting on its own transfer.
  always_comb begin
    for (int t = 0; t < TARGET_NUM; t++) begin
      tgtState_d[t]  = tgtState_q[t];
      claimId_d[t]   = claimId_q[t];
      err_d[t]       = 1'b0;
      resp[t]        = (busState_q == BUS_WAIT) && reg_ready_i && (owner_q == IW'(t));
      req[t]         = (tgtState_q[t] == CLAIM) || (tgtState_q[t] == COMPLETE);
      completeVec[t] = (tgtState_q[t] == COMPLETE);

      if (eoi_i[t] && (tgtState_q[t] != SERVICE)) begin
        err_d[t] = 1'b1;
      end

      case (tgtState_q[t])
        IDLE: begin
          if (irq_i[t]) begin
            tgtState_d[t] = CLAIM;
          end
        end
        CLAIM: begin
          if (resp[t]) begin
            if (reg_error_i) begin
              err_d[t]      = 1'b1;
              tgtState_d[t] = IDLE;
            end else if (reg_rdata_i[SRCW-1:0] == '0) begin
              tgtState_d[t] = IDLE;
            end else begin
              claimId_d[t]  = reg_rdata_i[SRCW-1:0];
              tgtState_d[t] = DELIVER;
            end
          end
        end
        DELIVER: begin
          if (irq_ack_i[t]) begin
            tgtState_d[t] = SERVICE;
          end
        end
        SERVICE: begin
          if (eoi_i[t]) begin
            tgtState_d[t] = COMPLETE;
          end
        end
        COMPLETE: begin
          if (resp[t]) begin
            tgtState_d[t] = IDLE;
            if (reg_error_i) begin
              err_d[t] = 1'b1;
            end
          end
        end
        default: tgtState_d[t] = IDLE;
      endcase
    end
  end

  // Payload registers only load on issue, so they hold through the whole wait.
  always_comb begin
    busState_d = busState_q;
    owner_d    = owner_q;
    regValid_d = regValid_q;
    regWrite_d = regWrite_q;
    regAddr_d  = regAddr_q;
    regWdata_d = regWdata_q;
    regWstrb_d = regWstrb_q;
    arbEn      = 1'b0;
    arbDone    = 1'b0;

    case (busState_q)
      BUS_IDLE: begin
        if (|req) begin
          arbEn      = 1'b1;
          owner_d    = gntIdx;
          busState_d = BUS_WAIT;
          regValid_d = 1'b1;
          regWrite_d = |(gnt & completeVec);
          regAddr_d  = ADDR_WIDTH'(cc_addr(64'(CC_BASE), 64'(CC_STRIDE), 32'(gntIdx)));
          regWdata_d = regWrite_d ? DATA_WIDTH'(claimId_q[gntIdx]) : '0;
          regWstrb_d = regWrite_d ? {SW{1'b1}} : '0;
        end
      end
      BUS_WAIT: begin
        if (reg_ready_i) begin
          arbDone    = 1'b1;
          regValid_d = 1'b0;
          busState_d = BUS_IDLE;
        end
      end
      default: busState_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < TARGET_NUM; t++) begin
        tgtState_q[t] <= IDLE;
        claimId_q[t]  <= '0;
      end
      err_q      <= '0;
      busState_q <= BUS_IDLE;
      owner_q    <= '0;
      regValid_q <= 1'b0;
      regWrite_q <= 1'b0;
      regAddr_q  <= '0;
      regWdata_q <= '0;
      regWstrb_q <= '0;
    end else begin
      for (int t = 0; t < TARGET_NUM; t++) begin
        tgtState_q[t] <= tgtState_d[t];
        claimId_q[t]  <= claimId_d[t];
      end
      err_q      <= err_d;
      busState_q <= busState_d;
      owner_q    <= owner_d;
      regValid_q <= regValid_d;
      regWrite_q <= regWrite_d;
      regAddr_q  <= regAddr_d;
      regWdata_q <= regWdata_d;
      regWstrb_q <= regWstrb_d;
    end
  end

  always_comb begin
    irq_valid_o = '0;
    irq_id_o    = '0;
    for (int t = 0; t < TARGET_NUM; t++) begin
      irq_valid_o[t]             = (tgtState_q[t] == DELIVER);
      irq_id_o[t*SRCW +: SRCW]   = claimId_q[t];
    end
  end

  assign err_o       = err_q;
  assign reg_valid_o = regValid_q;
  assign reg_write_o = regWrite_q;
  assign reg_addr_o  = regAddr_q;
  assign reg_wdata_o = regWdata_q;
  assign reg_wstrb_o = regWstrb_q;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Self-checking bench: directed claim/spurious/contention/error/reset steps,
// then random episodes checked against a per-target transaction-level model.
module tb_plic_claim_sequencer;

  localparam int TN   = 2;
  localparam int SRCW = 5;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam logic [AW-1:0] BASE   = 32'h0020_0004;
  localparam logic [AW-1:0] STRIDE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [TN-1:0] irq = '0, ack = '0, eoi = '0;
  logic [TN-1:0] irqValid, err;
  logic [TN*SRCW-1:0] irqId;
  logic regValid, regWrite;
  logic [AW-1:0] regAddr;
  logic [DW-1:0] regWdata;
  logic [DW/8-1:0] regWstrb;
  logic [DW-1:0] regRdata = '0;
  logic regError = 1'b0;
  logic regReady = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;

  // PLIC slave model configuration and observed transaction bookkeeping
  int respDelay = 0;
  logic [SRCW-1:0] respId [TN];
  bit rdErr [TN];
  bit wrErr [TN];
  int readsSeen [TN];
  int writesSeen [TN];
  int errSeen [TN];
  int validRises [TN];
  logic [SRCW-1:0] lastWdata [TN];

  typedef struct {
    bit write;
    int tgt;
  } xfer_t;
  xfer_t xferLog [$];

  plic_claim_sequencer #(
    .SOURCE_NUM (32),
    .TARGET_NUM (TN),
    .SRCW       (SRCW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CC_BASE    (BASE),
    .CC_STRIDE  (STRIDE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_i       (irq),
    .irq_valid_o (irqValid),
    .irq_id_o    (irqId),
    .irq_ack_i   (ack),
    .eoi_i       (eoi),
    .err_o       (err),
    .reg_valid_o (regValid),
    .reg_write_o (regWrite),
    .reg_addr_o  (regAddr),
    .reg_wdata_o (regWdata),
    .reg_wstrb_o (regWstrb),
    .reg_rdata_i (regRdata),
    .reg_error_i (regError),
    .reg_ready_i (regReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [TN-1:0] irqV, input logic [TN-1:0] ackV, input logic [TN-1:0] eoiV);
    irq = irqV;
    ack = ackV;
    eoi = eoiV;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_irq_valid"}, irqValid, 0);
    checkOutput({pfx, "_err"}, err, 0);
    checkOutput({pfx, "_reg_valid"}, regValid, 0);
    checkOutput({pfx, "_reg_write"}, regWrite, 0);
    checkOutput({pfx, "_reg_addr"}, regAddr, 0);
    checkOutput({pfx, "_reg_wdata"}, regWdata, 0);
    checkOutput({pfx, "_reg_wstrb"}, regWstrb, 0);
    checkOutput({pfx, "_irq_id"}, irqId, 0);
  endtask

  // Waits for the read (wr=0) or write (wr=1) count of target t to reach goal
  task automatic waitXfer(input int t, input bit wr, input int goal, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if ((wr ? writesSeen[t] : readsSeen[t]) >= goal) break;
      tick();
    end
    checkOutput(tag, wr ? writesSeen[t] : readsSeen[t], goal);
  endtask

  task automatic waitValid(input logic [TN-1:0] want, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (irqValid == want) break;
      tick();
    end
    checkOutput(tag, irqValid, want);
  endtask

  // PLIC register slave: decodes the target from the address, stalls for
  // respDelay cycles and verifies the payload does not move while waiting.
  bit active = 0;
  int waitCnt = 0;
  logic snapWrite;
  logic [AW-1:0] snapAddr, offs;
  logic [DW-1:0] snapWdata, rdRand;
  logic [DW/8-1:0] snapWstrb;
  int decTgt;
  bit decOk;

  always @(negedge clk) begin
    if (rst || !regValid) begin
      regReady = 1'b0;
      regError = 1'b0;
      active   = 0;
      waitCnt  = 0;
    end else if (!regReady) begin
      if (!active) begin
        active    = 1;
        waitCnt   = 0;
        snapWrite = regWrite;
        snapAddr  = regAddr;
        snapWdata = regWdata;
        snapWstrb = regWstrb;
      end else begin
        checkOutput("payload_write_stable", regWrite, snapWrite);
        checkOutput("payload_addr_stable", regAddr, snapAddr);
        checkOutput("payload_wdata_stable", regWdata, snapWdata);
        checkOutput("payload_wstrb_stable", regWstrb, snapWstrb);
      end
      if (waitCnt >= respDelay) begin
        offs   = regAddr - BASE;
        decOk  = (regAddr >= BASE) && ((offs % STRIDE) == 0) && ((offs / STRIDE) < TN);
        decTgt = decOk ? int'(offs / STRIDE) : 0;
        checkOutput("addr_decodes_to_target", decOk, 1);
        checkOutput("wstrb_matches_dir", regWstrb, regWrite ? 4'hF : 4'h0);
        if (decOk) begin
          if (regWrite) begin
            writesSeen[decTgt]++;
            lastWdata[decTgt] = regWdata[SRCW-1:0];
            checkOutput("write_data_zero_extended", regWdata, {{(DW-SRCW){1'b0}}, respId[decTgt]});
            regError = wrErr[decTgt];
          end else begin
            readsSeen[decTgt]++;
            rdRand = $urandom;
            rdRand[SRCW-1:0] = respId[decTgt];
            regRdata = rdRand;
            regError = rdErr[decTgt];
          end
          xferLog.push_back('{write: regWrite, tgt: decTgt});
        end
        regReady = 1'b1;
      end else begin
        waitCnt++;
      end
    end
  end

  logic [TN-1:0] prevValid = '0;
  always @(negedge clk) begin
    if (rst) begin
      prevValid = '0;
    end else begin
      for (int t = 0; t < TN; t++) begin
        if (err[t]) errSeen[t]++;
        if (irqValid[t] && !prevValid[t]) validRises[t]++;
      end
      prevValid = irqValid;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, e1, v0, v1, r0, r1, w0, w1, logSz;
    for (int t = 0; t < TN; t++) begin
      respId[t] = '0;
      rdErr[t] = 0;
      wrErr[t] = 0;
      readsSeen[t] = 0;
      writesSeen[t] = 0;
      errSeen[t] = 0;
      validRises[t] = 0;
      lastWdata[t] = '0;
    end

    // Reset state
    applyStimulus('0, '0, '0);
    rst = 1'b1;
    repeat (2) tick();
    checkResetValues("reset");
    rst = 1'b0;
    tick();

    // Single claim with exact latencies, then ack, eoi and write-back
    $display("[TB] single claim");
    respDelay = 0;
    respId[0] = 5'd5;
    applyStimulus(2'b01, '0, '0);
    tick();
    checkOutput("t1_no_valid_after_edge0", regValid, 0);
    tick();
    checkOutput("t1_read_valid", regValid, 1);
    checkOutput("t1_read_dir", regWrite, 0);
    checkOutput("t1_read_addr", regAddr, 32'h0020_0004);
    checkOutput("t1_read_wstrb", regWstrb, 0);
    irq = '0;
    tick();
    checkOutput("t1_irq_valid", irqValid, 2'b01);
    checkOutput("t1_irq_id", irqId[SRCW-1:0], 5);
    checkOutput("t1_bus_released", regValid, 0);
    ack = 2'b01;
    tick();
    ack = '0;
    checkOutput("t1_valid_drops_after_ack", irqValid, 0);
    eoi = 2'b01;
    tick();
    eoi = '0;
    checkOutput("t1_no_write_yet", regValid, 0);
    tick();
    checkOutput("t1_write_valid", regValid, 1);
    checkOutput("t1_write_dir", regWrite, 1);
    checkOutput("t1_write_addr", regAddr, 32'h0020_0004);
    checkOutput("t1_write_wdata", regWdata, 5);
    checkOutput("t1_write_wstrb", regWstrb, 4'hF);
    tick();
    checkOutput("t1_write_done", writesSeen[0], 1);
    checkOutput("t1_no_err", errSeen[0], 0);

    // Spurious claim on target 1
    $display("[TB] spurious claim");
    respId[1] = '0;
    e1 = errSeen[1];
    v1 = validRises[1];
    irq = 2'b10;
    waitXfer(1, 0, 1, 20, "t2_read_issued");
    irq = '0;
    repeat (4) tick();
    checkOutput("t2_no_delivery", validRises[1], v1);
    checkOutput("t2_no_err", errSeen[1], e1);
    checkOutput("t2_bus_idle", regValid, 0);

    // Contention with slow ready: strict round-robin order for reads and writes
    $display("[TB] contention");
    respDelay = 3;
    respId[0] = 5'd7;
    respId[1] = 5'd9;
    r1 = readsSeen[1];
    w1 = writesSeen[1];
    xferLog.delete();
    irq = 2'b11;
    waitXfer(1, 0, r1 + 1, 60, "t3_reads_done");
    irq = '0;
    checkOutput("t3_read_count", xferLog.size(), 2);
    if (xferLog.size() >= 2) begin
      checkOutput("t3_first_read_tgt", xferLog[0].tgt, 0);
      checkOutput("t3_second_read_tgt", xferLog[1].tgt, 1);
      checkOutput("t3_second_read_dir", xferLog[1].write, 0);
    end
    waitValid(2'b11, 10, "t3_both_valid");
    checkOutput("t3_id0", irqId[0 +: SRCW], 7);
    checkOutput("t3_id1", irqId[SRCW +: SRCW], 9);
    ack = 2'b11;
    tick();
    ack = '0;
    eoi = 2'b11;
    tick();
    eoi = '0;
    waitXfer(1, 1, w1 + 1, 60, "t3_writes_done");
    checkOutput("t3_total_xfers", xferLog.size(), 4);
    if (xferLog.size() >= 4) begin
      checkOutput("t3_first_write_tgt", xferLog[2].tgt, 0);
      checkOutput("t3_second_write_tgt", xferLog[3].tgt, 1);
    end
    checkOutput("t3_wdata0", lastWdata[0], 7);
    checkOutput("t3_wdata1", lastWdata[1], 9);
    tick();

    // Claim error and stray eoi / ack
    $display("[TB] errors");
    respDelay = 1;
    rdErr[0] = 1;
    respId[0] = 5'd12;
    e0 = errSeen[0];
    v0 = validRises[0];
    r0 = readsSeen[0];
    irq = 2'b01;
    waitXfer(0, 0, r0 + 1, 20, "t4_err_read_issued");
    irq = '0;
    repeat (3) tick();
    rdErr[0] = 0;
    checkOutput("t4_claim_err_pulse", errSeen[0], e0 + 1);
    checkOutput("t4_claim_err_no_delivery", validRises[0], v0);
    e1 = errSeen[1];
    logSz = xferLog.size();
    eoi = 2'b10;
    tick();
    eoi = '0;
    repeat (3) tick();
    checkOutput("t4_stray_eoi_err", errSeen[1], e1 + 1);
    checkOutput("t4_stray_eoi_no_bus", xferLog.size(), logSz);
    e0 = errSeen[0];
    ack = 2'b01;
    tick();
    ack = '0;
    repeat (2) tick();
    checkOutput("t4_stray_ack_silent", errSeen[0], e0);
    checkOutput("t4_stray_ack_no_valid", irqValid, 0);

    // Reset in the middle of a stalled claim read
    $display("[TB] reset mid-transfer");
    respDelay = 30;
    respId[0] = 5'd3;
    irq = 2'b01;
    for (int i = 0; i < 10; i++) begin
      if (regValid) break;
      tick();
    end
    checkOutput("t5_read_pending", regValid, 1);
    tick();
    rst = 1'b1;
    tick();
    checkResetValues("t5_after_reset");
    rst = 1'b0;
    respDelay = 0;
    xferLog.delete();
    r0 = readsSeen[0];
    w0 = writesSeen[0];
    waitXfer(0, 0, r0 + 1, 20, "t5_fresh_claim");
    irq = '0;
    if (xferLog.size() >= 1) begin
      checkOutput("t5_fresh_claim_tgt", xferLog[0].tgt, 0);
      checkOutput("t5_fresh_claim_dir", xferLog[0].write, 0);
    end
    waitValid(2'b01, 10, "t5_fresh_valid");
    checkOutput("t5_fresh_id", irqId[0 +: SRCW], 3);
    ack = 2'b01;
    tick();
    ack = '0;
    eoi = 2'b01;
    tick();
    eoi = '0;
    waitXfer(0, 1, w0 + 1, 20, "t5_fresh_complete");
    tick();

    // Random episodes against a transaction-level expectation per target
    $display("[TB] random episodes");
    for (int ep = 0; ep < 25; ep++) begin
      logic [TN-1:0] act;
      int rb [TN];
      int wb [TN];
      int eb [TN];
      int vb [TN];
      bit good [TN];
      int ph [TN];
      int cnt [TN];
      bit done;
      act = TN'($urandom_range(1, 3));
      respDelay = $urandom_range(0, 3);
      for (int t = 0; t < TN; t++) begin
        respId[t] = ($urandom_range(0, 3) == 0) ? '0 : SRCW'($urandom_range(1, 31));
        rdErr[t]  = ($urandom_range(0, 4) == 0);
        wrErr[t]  = ($urandom_range(0, 4) == 0);
        good[t]   = act[t] && !rdErr[t] && (respId[t] != 0);
        rb[t] = readsSeen[t];
        wb[t] = writesSeen[t];
        eb[t] = errSeen[t];
        vb[t] = validRises[t];
        ph[t] = good[t] ? 0 : 3;
        cnt[t] = 0;
      end
      irq = act;
      done = 0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
        tick();
        ack = '0;
        eoi = '0;
        for (int t = 0; t < TN; t++) begin
          if (readsSeen[t] > rb[t]) irq[t] = 1'b0;
          case (ph[t])
            0: if (irqValid[t]) begin
              checkOutput("rnd_irq_id", irqId[t*SRCW +: SRCW], respId[t]);
              cnt[t] = $urandom_range(0, 3);
              ph[t] = 1;
            end
            1: if (cnt[t] == 0) begin
              ack[t] = 1'b1;
              cnt[t] = $urandom_range(0, 4);
              ph[t] = 2;
            end else begin
              cnt[t]--;
            end
            2: if (cnt[t] == 0) begin
              eoi[t] = 1'b1;
              ph[t] = 3;
            end else begin
              cnt[t]--;
            end
            default: ;
          endcase
        end
        done = 1;
        for (int t = 0; t < TN; t++) begin
          if (act[t] && readsSeen[t] == rb[t]) done = 0;
          if (good[t] && writesSeen[t] == wb[t]) done = 0;
        end
      end
      checkOutput("rnd_episode_finished", done, 1);
      applyStimulus('0, '0, '0);
      repeat (6) tick();
      for (int t = 0; t < TN; t++) begin
        checkOutput("rnd_reads", readsSeen[t] - rb[t], act[t] ? 1 : 0);
        checkOutput("rnd_writes", writesSeen[t] - wb[t], good[t] ? 1 : 0);
        checkOutput("rnd_deliveries", validRises[t] - vb[t], good[t] ? 1 : 0);
        checkOutput("rnd_errors", errSeen[t] - eb[t],
                    (act[t] && (rdErr[t] || (good[t] && wrErr[t]))) ? 1 : 0);
        if (good[t]) checkOutput("rnd_wdata", lastWdata[t], respId[t]);
      end
      checkOutput("rnd_bus_idle", regValid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
